// File: rtl/mod_cache_arbiter.sv
// mod_cache_arbiter: round-robin arbiter sharing one memory bus between the
// L1 instruction cache (i) and the L1 data cache (d). One transaction is in
// flight at a time; the grant is held until the response is consumed.
module mod_cache_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned TAG_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  // instruction cache port
  input  logic              i_reqcyc,
  output logic              i_reqack,
  input  logic [ADDR_W-1:0] i_req,
  input  logic [TAG_W-1:0]  i_reqtag,
  input  logic [DATA_W-1:0] i_reqdata,
  output logic              i_respcyc,
  input  logic              i_respack,
  output logic [DATA_W-1:0] i_resp,
  output logic [TAG_W-1:0]  i_resptag,
  // data cache port
  input  logic              d_reqcyc,
  output logic              d_reqack,
  input  logic [ADDR_W-1:0] d_req,
  input  logic [TAG_W-1:0]  d_reqtag,
  input  logic [DATA_W-1:0] d_reqdata,
  output logic              d_respcyc,
  input  logic              d_respack,
  output logic [DATA_W-1:0] d_resp,
  output logic [TAG_W-1:0]  d_resptag,
  // memory port
  output logic              m_reqcyc,
  input  logic              m_reqack,
  output logic [ADDR_W-1:0] m_req,
  output logic [TAG_W-1:0]  m_reqtag,
  output logic [DATA_W-1:0] m_reqdata,
  input  logic              m_respcyc,
  output logic              m_respack,
  input  logic [DATA_W-1:0] m_resp,
  input  logic [TAG_W-1:0]  m_resptag
);

  localparam int unsigned OFFS_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RESP, S_DELIVER} state_e;

  // Requester encoding for owner/last: 0 = i, 1 = d.
  state_e            state_q;
  logic              owner_q;
  logic              last_q;

  logic              grant_valid_c;
  logic              grant_sel_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [TAG_W-1:0]  sel_tag_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              owner_ack_c;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_valid_c = i_reqcyc | d_reqcyc;
    grant_sel_c   = d_reqcyc & (~i_reqcyc | ~last_q);
    sel_addr_c    = grant_sel_c ? d_req     : i_req;
    sel_tag_c     = grant_sel_c ? d_reqtag  : i_reqtag;
    sel_data_c    = grant_sel_c ? d_reqdata : i_reqdata;
    owner_ack_c   = owner_q ? d_respack : i_respack;
  end

  // Memory response is accepted only while waiting for it.
  assign m_respack = (state_q == S_WAIT_RESP) & m_respcyc;

  // Arbitration FSM with registered request/response datapaths.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      i_reqack  <= 1'b0;
      d_reqack  <= 1'b0;
      i_respcyc <= 1'b0;
      d_respcyc <= 1'b0;
      i_resp    <= '0;
      d_resp    <= '0;
      i_resptag <= '0;
      d_resptag <= '0;
      m_reqcyc  <= 1'b0;
      m_req     <= '0;
      m_reqtag  <= '0;
      m_reqdata <= '0;
    end else begin
      i_reqack <= 1'b0;
      d_reqack <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_valid_c) begin
            owner_q   <= grant_sel_c;
            last_q    <= grant_sel_c;
            i_reqack  <= ~grant_sel_c;
            d_reqack  <= grant_sel_c;
            m_reqcyc  <= 1'b1;
            m_req     <= {sel_addr_c[ADDR_W-1:OFFS_W], OFFS_W'(0)};
            m_reqtag  <= sel_tag_c;
            m_reqdata <= sel_data_c;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_reqack) begin
            m_reqcyc <= 1'b0;
            state_q  <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (m_respcyc) begin
            if (owner_q) begin
              d_respcyc <= 1'b1;
              d_resp    <= m_resp;
              d_resptag <= m_resptag;
            end else begin
              i_respcyc <= 1'b1;
              i_resp    <= m_resp;
              i_resptag <= m_resptag;
            end
            state_q <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (owner_ack_c) begin
            i_respcyc <= 1'b0;
            d_respcyc <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// Directed bench for mod_cache_arbiter: cycle-exact stimulus with
// hand-computed expectations, one task per scenario.
module tb_mod_cache_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned TAG_W  = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_reqcyc, i_reqack, i_respcyc, i_respack;
  logic [ADDR_W-1:0] i_req;
  logic [TAG_W-1:0]  i_reqtag, i_resptag;
  logic [DATA_W-1:0] i_reqdata, i_resp;
  logic              d_reqcyc, d_reqack, d_respcyc, d_respack;
  logic [ADDR_W-1:0] d_req;
  logic [TAG_W-1:0]  d_reqtag, d_resptag;
  logic [DATA_W-1:0] d_reqdata, d_resp;
  logic              m_reqcyc, m_reqack, m_respcyc, m_respack;
  logic [ADDR_W-1:0] m_req;
  logic [TAG_W-1:0]  m_reqtag, m_resptag;
  logic [DATA_W-1:0] m_reqdata, m_resp;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [DATA_W-1:0] DATA_A5 = {16{32'hA5A5A5A5}};
  localparam logic [DATA_W-1:0] DATA_WR = {16{32'h12345678}};
  localparam logic [DATA_W-1:0] DATA_C3 = {16{32'hC3C3_0F0F}};

  always #5 clk = ~clk;

  mod_cache_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_reqack(i_reqack), .i_req(i_req), .i_reqtag(i_reqtag),
    .i_reqdata(i_reqdata), .i_respcyc(i_respcyc), .i_respack(i_respack),
    .i_resp(i_resp), .i_resptag(i_resptag),
    .d_reqcyc(d_reqcyc), .d_reqack(d_reqack), .d_req(d_req), .d_reqtag(d_reqtag),
    .d_reqdata(d_reqdata), .d_respcyc(d_respcyc), .d_respack(d_respack),
    .d_resp(d_resp), .d_resptag(d_resptag),
    .m_reqcyc(m_reqcyc), .m_reqack(m_reqack), .m_req(m_req), .m_reqtag(m_reqtag),
    .m_reqdata(m_reqdata), .m_respcyc(m_respcyc), .m_respack(m_respack),
    .m_resp(m_resp), .m_resptag(m_resptag)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory handshake plus owner consumption for a request already in ISSUE.
  task automatic finish_txn(input bit to_d, input logic [DATA_W-1:0] data);
    m_reqack = 1'b1;
    tick();
    m_reqack  = 1'b0;
    m_respcyc = 1'b1;
    m_resp    = data;
    m_resptag = 13'h0AA;
    tick();
    m_respcyc = 1'b0;
    if (to_d) d_respack = 1'b1; else i_respack = 1'b1;
    tick();
    d_respack = 1'b0;
    i_respack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_total++;
    if ({i_reqack, d_reqack, i_respcyc, d_respcyc, m_reqcyc, m_respack} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {i_reqack, d_reqack, i_respcyc, d_respcyc, m_reqcyc, m_respack});
    else n_pass++;
    n_total++;
    if (m_req !== '0 || m_reqtag !== '0 || m_reqdata !== '0 || i_resp !== '0 || d_resptag !== '0)
      $display("FAIL reset_data: m_req=%h m_reqtag=%h want 0", m_req, m_reqtag);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_d_read();
    d_reqcyc = 1'b1;
    d_req    = 64'h0000_0000_1000_0040;
    d_reqtag = 13'h001;
    tick();
    n_total++;
    if ({d_reqack, i_reqack, m_reqcyc} !== 3'b101)
      $display("FAIL rd_grant: d_reqack,i_reqack,m_reqcyc=%b want 101", {d_reqack, i_reqack, m_reqcyc});
    else n_pass++;
    n_total++;
    if (m_req !== 64'h1000_0040 || m_reqtag !== 13'h001)
      $display("FAIL rd_mreq: m_req=%h tag=%h want 10000040/001", m_req, m_reqtag);
    else n_pass++;
    d_reqcyc = 1'b0;
    m_reqack = 1'b1;
    tick();
    n_total++;
    if ({d_reqack, m_reqcyc} !== 2'b00)
      $display("FAIL rd_issue_done: d_reqack,m_reqcyc=%b want 00", {d_reqack, m_reqcyc});
    else n_pass++;
    m_reqack  = 1'b0;
    m_respcyc = 1'b1;
    m_resp    = DATA_A5;
    m_resptag = 13'h001;
    #1;
    n_total++;
    if (m_respack !== 1'b1) $display("FAIL rd_respack: got %b want 1", m_respack);
    else n_pass++;
    tick();
    n_total++;
    if (d_respcyc !== 1'b1 || d_resp !== DATA_A5 || d_resptag !== 13'h001)
      $display("FAIL rd_deliver: d_respcyc=%b d_resptag=%h d_resp=%h", d_respcyc, d_resptag, d_resp);
    else n_pass++;
    n_total++;
    if (i_respcyc !== 1'b0 || m_respack !== 1'b0)
      $display("FAIL rd_no_i_or_reack: i_respcyc=%b m_respack=%b want 0 0", i_respcyc, m_respack);
    else n_pass++;
    m_respcyc = 1'b0;
    d_respack = 1'b1;
    tick();
    d_respack = 1'b0;
    n_total++;
    if (d_respcyc !== 1'b0) $display("FAIL rd_release: d_respcyc=%b want 0", d_respcyc);
    else n_pass++;
  endtask

  task automatic test_unaligned();
    i_reqcyc = 1'b1;
    i_req    = 64'h0000_0000_2000_007F;
    i_reqtag = 13'h002;
    tick();
    i_reqcyc = 1'b0;
    n_total++;
    if (i_reqack !== 1'b1 || m_req !== 64'h2000_0040)
      $display("FAIL unaligned: i_reqack=%b m_req=%h want 1/20000040", i_reqack, m_req);
    else n_pass++;
    m_reqack = 1'b1;
    tick();
    m_reqack  = 1'b0;
    m_respcyc = 1'b1;
    m_resp    = DATA_C3;
    m_resptag = 13'h002;
    tick();
    m_respcyc = 1'b0;
    n_total++;
    if (i_respcyc !== 1'b1 || d_respcyc !== 1'b0 || i_resp !== DATA_C3)
      $display("FAIL unaligned_resp: i_respcyc=%b d_respcyc=%b want 1 0", i_respcyc, d_respcyc);
    else n_pass++;
    i_respack = 1'b1;
    tick();
    i_respack = 1'b0;
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_req = 64'h3000_0000; i_reqtag = 13'h010;
    d_req = 64'h4000_0000; d_reqtag = 13'h020;
    i_reqcyc = 1'b1;
    d_reqcyc = 1'b1;
    tick();
    n_total++;
    if ({d_reqack, i_reqack} !== 2'b10 || m_req !== 64'h4000_0000)
      $display("FAIL rr_first_d: d_reqack,i_reqack=%b m_req=%h want 10/40000000", {d_reqack, i_reqack}, m_req);
    else n_pass++;
    d_reqcyc = 1'b0;
    finish_txn(1'b1, DATA_A5);
    tick();
    n_total++;
    if ({d_reqack, i_reqack} !== 2'b01 || m_req !== 64'h3000_0000)
      $display("FAIL rr_then_i: d_reqack,i_reqack=%b m_req=%h want 01/30000000", {d_reqack, i_reqack}, m_req);
    else n_pass++;
    i_reqcyc = 1'b0;
    finish_txn(1'b0, DATA_C3);
    i_reqcyc = 1'b1;
    d_reqcyc = 1'b1;
    tick();
    n_total++;
    if ({d_reqack, i_reqack} !== 2'b10)
      $display("FAIL rr_again_d: d_reqack,i_reqack=%b want 10", {d_reqack, i_reqack});
    else n_pass++;
    d_reqcyc = 1'b0;
    finish_txn(1'b1, DATA_A5);
    tick();
    i_reqcyc = 1'b0;
    finish_txn(1'b0, DATA_C3);
  endtask

  task automatic test_write();
    d_reqcyc  = 1'b1;
    d_req     = 64'h5000_0080;
    d_reqtag  = 13'h1005;
    d_reqdata = DATA_WR;
    tick();
    d_reqcyc = 1'b0;
    n_total++;
    if (m_reqdata !== DATA_WR || m_reqtag !== 13'h1005 || d_reqack !== 1'b1)
      $display("FAIL wr_payload: m_reqtag=%h m_reqdata=%h", m_reqtag, m_reqdata);
    else n_pass++;
    m_reqack = 1'b1;
    tick();
    m_reqack  = 1'b0;
    m_respcyc = 1'b1;
    m_resp    = '0;
    m_resptag = 13'h1005;
    tick();
    m_respcyc = 1'b0;
    n_total++;
    if (d_respcyc !== 1'b1 || d_resptag !== 13'h1005 || i_respcyc !== 1'b0)
      $display("FAIL wr_complete: d_respcyc=%b d_resptag=%h i_respcyc=%b", d_respcyc, d_resptag, i_respcyc);
    else n_pass++;
    d_respack = 1'b1;
    tick();
    d_respack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    d_reqcyc = 1'b1;
    d_req    = 64'h6000_0000;
    d_reqtag = 13'h033;
    tick();
    d_reqcyc = 1'b0;
    i_reqcyc = 1'b1;
    i_req    = 64'h7000_0000;
    i_reqtag = 13'h044;
    m_reqack = 1'b1;
    tick();
    m_reqack  = 1'b0;
    m_respcyc = 1'b1;
    m_resp    = DATA_A5;
    m_resptag = 13'h033;
    tick();
    m_respcyc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (d_respcyc !== 1'b1 || d_resp !== DATA_A5 || i_reqack !== 1'b0)
        $display("FAIL hold_%0d: d_respcyc=%b i_reqack=%b want 1 0", k, d_respcyc, i_reqack);
      else n_pass++;
      tick();
    end
    d_respack = 1'b1;
    tick();
    d_respack = 1'b0;
    n_total++;
    if (d_respcyc !== 1'b0 || i_reqack !== 1'b0)
      $display("FAIL hold_release: d_respcyc=%b i_reqack=%b want 0 0", d_respcyc, i_reqack);
    else n_pass++;
    tick();
    n_total++;
    if (i_reqack !== 1'b1 || m_req !== 64'h7000_0000)
      $display("FAIL pending_i_grant: i_reqack=%b m_req=%h want 1/70000000", i_reqack, m_req);
    else n_pass++;
    i_reqcyc = 1'b0;
    finish_txn(1'b0, DATA_C3);
  endtask

  task automatic test_reset_mid();
    i_reqcyc = 1'b1;
    i_req    = 64'h8000_0000;
    i_reqtag = 13'h055;
    tick();
    i_reqcyc = 1'b0;
    m_reqack = 1'b1;
    tick();
    m_reqack = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if ({i_reqack, d_reqack, i_respcyc, d_respcyc, m_reqcyc, m_respack} !== 6'b0 || m_req !== '0)
      $display("FAIL midreset_outs: ctrl=%b m_req=%h want 0",
               {i_reqack, d_reqack, i_respcyc, d_respcyc, m_reqcyc, m_respack}, m_req);
    else n_pass++;
    m_respcyc = 1'b1;
    m_resp    = DATA_A5;
    #1;
    n_total++;
    if (m_respack !== 1'b0) $display("FAIL midreset_noack: m_respack=%b want 0", m_respack);
    else n_pass++;
    tick();
    m_respcyc = 1'b0;
    n_total++;
    if (i_respcyc !== 1'b0) $display("FAIL midreset_nodeliver: i_respcyc=%b want 0", i_respcyc);
    else n_pass++;
    i_reqcyc = 1'b1;
    i_req    = 64'h9000_0010;
    tick();
    i_reqcyc = 1'b0;
    n_total++;
    if (i_reqack !== 1'b1 || m_req !== 64'h9000_0000)
      $display("FAIL midreset_fresh: i_reqack=%b m_req=%h want 1/90000000", i_reqack, m_req);
    else n_pass++;
    m_reqack = 1'b1;
    tick();
    m_reqack  = 1'b0;
    m_respcyc = 1'b1;
    m_resp    = DATA_C3;
    tick();
    m_respcyc = 1'b0;
    n_total++;
    if (i_respcyc !== 1'b1 || i_resp !== DATA_C3)
      $display("FAIL midreset_fresh_resp: i_respcyc=%b want 1", i_respcyc);
    else n_pass++;
    i_respack = 1'b1;
    tick();
    i_respack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_reqcyc = 1'b0; i_req = '0; i_reqtag = '0; i_reqdata = '0; i_respack = 1'b0;
    d_reqcyc = 1'b0; d_req = '0; d_reqtag = '0; d_reqdata = '0; d_respack = 1'b0;
    m_reqack = 1'b0; m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
    test_reset();
    test_single_d_read();
    test_unaligned();
    test_round_robin();
    test_write();
    test_delayed_ack();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_cache_arbiter.md
# mod_cache_arbiter

Shares the single memory-side bus between the L1 instruction cache and the L1 data cache. It sits between the two cache controllers' arbiter-facing ports and the memory/bus port. It accepts one block request at a time, chosen round-robin. It forwards that request downstream, holds the grant until the response returns, and routes the response back to the requester that issued it. Exactly one transaction is outstanding at any time.

## Interface
Parameters:
- ADDR_W, 64, request address width
- DATA_W, 512, block payload width (64-byte line)
- TAG_W, 13, request/response tag width; bit TAG_W-1 is the write flag

Ports (requester r ∈ {i, d}; i = instruction cache, d = data cache):
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- r_reqcyc  in  1  requester r has a valid request
- r_reqack  out  1  one-cycle pulse: request from r captured
- r_req  in  ADDR_W  request address
- r_reqtag  in  TAG_W  request tag
- r_reqdata  in  DATA_W  write payload; ignored for reads
- r_respcyc  out  1  response valid to r
- r_respack  in  1  r consumed the response
- r_resp  out  DATA_W  response data
- r_resptag  out  TAG_W  response tag
- m_reqcyc  out  1  request valid to memory
- m_reqack  in  1  memory accepted the request
- m_req  out  ADDR_W  forwarded address, low 6 bits forced to 0
- m_reqtag  out  TAG_W  forwarded tag
- m_reqdata  out  DATA_W  forwarded payload
- m_respcyc  in  1  memory response valid
- m_respack  out  1  arbiter accepts the memory response
- m_resp  in  DATA_W  memory response data
- m_resptag  in  TAG_W  memory response tag

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP, DELIVER.
- Internal registers:
  - owner (1 bit): requester currently holding the grant.
  - last (1 bit): requester most recently granted; reset value = i, so d wins the first tie.
- IDLE:
  - If exactly one r_reqcyc is high, grant that requester.
  - If both are high, grant the requester that is not `last`.
  - On a grant: latch req/reqtag/reqdata into the m_* registers with m_req[5:0] = 0. Set owner and last. Pulse r_reqack for the owner. Assert m_reqcyc. Go to ISSUE.
- ISSUE:
  - Hold m_reqcyc and the m_* payload stable.
  - When m_reqack = 1, drop m_reqcyc on the next cycle and go to WAIT_RESP.
- WAIT_RESP:
  - m_respack = m_respcyc. This is combinational and is asserted only in this state.
  - When m_respcyc = 1, latch m_resp/m_resptag into the owner's r_resp/r_resptag. Assert the owner's r_respcyc. Go to DELIVER.
- DELIVER:
  - Hold the owner's r_respcyc, r_resp and r_resptag stable until the owner's r_respack = 1.
  - Then clear r_respcyc and go to IDLE.
- Writes (tag bit TAG_W-1 = 1) follow the same path. The memory's respcyc acts as the write completion and is delivered to the owner.
- The non-owner's r_respcyc is never asserted.
- An r_reqcyc arriving outside IDLE is not acknowledged. It stays pending and is arbitrated on the next IDLE cycle.
- A requester must drop r_reqcyc in the cycle after it sees r_reqack. While r_reqack is high, IDLE is not re-entered, so there is no double grant.
- m_resptag is passed through unmodified. The arbiter does not check it.
- Reset:
  - All outputs are 0: r_reqack, r_respcyc, r_resp, r_resptag, m_reqcyc, m_req, m_reqtag, m_reqdata. m_respack is 0 because the state is not WAIT_RESP.
  - State = IDLE, last = i.
  - Reset mid-transaction abandons the transaction. No response is delivered for it.

## Timing
- IDLE sees r_reqcyc at edge N. r_reqack and m_reqcyc are high after edge N. r_reqack is low after edge N+1.
- Minimum latency from request to m_reqcyc is 1 cycle.
- m_reqack seen at edge K gives m_reqcyc = 0 after edge K. The earliest m_respcyc that is accepted is at edge K+1.
- m_respcyc seen at edge R gives owner r_respcyc = 1 after edge R. m_respack is high during the cycle before edge R.
- Owner r_respack seen at edge A gives r_respcyc = 0 and IDLE after edge A. A new grant is possible at edge A+1.
- Best-case turnaround is 4 cycles plus memory latency.
- The memory may hold m_respcyc for more than one cycle. Only the first cycle in WAIT_RESP is captured. Later cycles are ignored and not acked, because the state is then DELIVER.

## Test plan
- Single d read: d_req=0x1000_0040, tag 0x001 -> d_reqack pulse 1 cycle later; m_req=0x1000_0040. Memory returns resp=0xA5…A5 -> d_respcyc with that data. i_respcyc stays 0.
- Unaligned address: i_req=0x2000_007F -> m_req=0x2000_0040.
- Simultaneous i and d requests straight after reset -> d is granted first. Once d completes, i is granted. Then both high again -> d first again, because last=i after the i transaction.
- d write, tag MSB=1, reqdata=0x1234…: m_reqdata matches exactly. The memory's respcyc completes the write -> d_respcyc. No transfer occurs on i.
- Owner delays r_respack by 5 cycles -> r_respcyc and r_resp stay stable for 5 cycles. A pending i_reqcyc is not acked until after IDLE.
- Reset asserted during WAIT_RESP -> all outputs 0 on the next cycle. A later m_respcyc is not acked. A fresh i request then proceeds normally.
